// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU.
//   ALU_W            datapath width (32)
//   ALU_AND..ALU_NOR 4-bit operation select codes; 1011-1111 are reserved
//   SH_SLL/SRL/SRA   2-bit mode codes for alu_shifter
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 32-bit barrel shifter.
//   val_i   [31:0] value to shift
//   shamt_i [4:0]  shift amount 0..31
//   mode_i  [1:0]  SH_SLL / SH_SRL / SH_SRA
//   res_o   [31:0] shifted value (0 for the unused mode code)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] val_i,
  input  logic [4:0]       shamt_i,
  input  logic [1:0]       mode_i,
  output logic [ALU_W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (mode_i)
      SH_SLL:  res_o = val_i << shamt_i;
      SH_SRL:  res_o = val_i >> shamt_i;
      SH_SRA:  res_o = $unsigned($signed(val_i) >>> shamt_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: 32-bit integer ALU with a registered result (1-cycle latency).
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (out=0, zero=1, out_valid=0)
//   in_valid   a/b/sel valid this cycle
//   a, b       operands; b[4:0] is the shift amount for shifts
//   sel        operation select (see alu_pkg)
//   out_valid  out/zero hold a fresh result
//   out        registered result
//   zero       registered flag, 1 when out == 0
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  output logic [ALU_W-1:0] out,
  output logic             zero
);

  logic             sub_w;
  logic [ALU_W-1:0] b_op_w;
  logic [ALU_W:0]   sum_w;
  logic             slt_w;
  logic             sltu_w;
  logic [1:0]       sh_mode_w;
  logic [ALU_W-1:0] sh_res_w;
  logic [ALU_W-1:0] res_d;
  logic             zero_d;
  logic [ALU_W-1:0] out_q;
  logic             zero_q;
  logic             vld_q;

  // One adder serves ADD, SUB and both compares: everything except ADD
  // computes a + ~b + 1.
  assign sub_w  = (sel != ALU_ADD);
  assign b_op_w = sub_w ? ~b : b;
  assign sum_w  = {1'b0, a} + {1'b0, b_op_w} + {{ALU_W{1'b0}}, sub_w};

  // Carry out of a - b is set when a >= b unsigned.
  assign sltu_w = ~sum_w[ALU_W];
  // Differing signs decide directly; equal signs cannot overflow, so the
  // difference sign is exact.
  assign slt_w  = (a[ALU_W-1] != b[ALU_W-1]) ? a[ALU_W-1] : sum_w[ALU_W-1];

  always_comb begin
    sh_mode_w = SH_SLL;
    case (sel)
      ALU_SRL: sh_mode_w = SH_SRL;
      ALU_SRA: sh_mode_w = SH_SRA;
      default: sh_mode_w = SH_SLL;
    endcase
  end

  alu_shifter u_shifter (
    .val_i   (a),
    .shamt_i (b[4:0]),
    .mode_i  (sh_mode_w),
    .res_o   (sh_res_w)
  );

  always_comb begin
    res_d = '0;
    case (sel)
      ALU_AND:  res_d = a & b;
      ALU_OR:   res_d = a | b;
      ALU_ADD:  res_d = sum_w[ALU_W-1:0];
      ALU_SUB:  res_d = sum_w[ALU_W-1:0];
      ALU_XOR:  res_d = a ^ b;
      ALU_SLT:  res_d = {{(ALU_W-1){1'b0}}, slt_w};
      ALU_SLTU: res_d = {{(ALU_W-1){1'b0}}, sltu_w};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  res_d = sh_res_w;
      ALU_NOR:  res_d = ~(a | b);
      default:  res_d = '0;
    endcase
  end

  // Flag comes from the value being loaded so out and zero never disagree.
  assign zero_d = (res_d == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      zero_q <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        out_q  <= res_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out       = out_q;
  assign zero      = zero_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  sel;
  logic        out_valid;
  logic [31:0] out;
  logic        zero;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out       (out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: the opcode table evaluated with plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] s, input logic [31:0] x,
                                        input logic [31:0] y);
    int unsigned sh;
    longint      xs;
    longint      ys;
    sh = y % 32;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    case (s)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
      4'd3:    return 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'd4:    return x ^ y;
      4'd5:    return (xs < ys) ? 32'd1 : 32'd0;
      4'd6:    return (x < y) ? 32'd1 : 32'd0;
      4'd7:    return 32'(longint'(x) * (64'd1 << sh));
      4'd8:    return 32'(longint'(x) / (64'd1 << sh));
      4'd9:    return 32'((xs >= 0) ? xs / (64'sd1 << sh)
                                    : -((-xs + (64'sd1 << sh) - 1) / (64'sd1 << sh)));
      4'd10:   return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  // Literal-expectation side channel: 0 none, 1 value, 2 reset state, 3 hold.
  int          lit_mode = 0;
  logic [31:0] lit_exp  = '0;
  string       lit_name = "";

  logic        started = 1'b0;
  logic [31:0] exp_out;
  logic        exp_zero;
  logic        exp_vld;
  int          chk_mode = 0;
  logic [31:0] chk_exp;
  string       chk_name;
  logic [3:0]  chk_sel;
  logic [31:0] chk_a, chk_b;

  always @(posedge clk) begin
    started  <= 1'b1;
    chk_mode <= lit_mode;
    chk_exp  <= lit_exp;
    chk_name <= lit_name;
    chk_sel  <= sel;
    chk_a    <= a;
    chk_b    <= b;
    if (!rst_n) begin
      exp_out  <= 32'd0;
      exp_zero <= 1'b1;
      exp_vld  <= 1'b0;
    end else begin
      exp_vld <= in_valid;
      if (in_valid) begin
        exp_out  <= model(sel, a, b);
        exp_zero <= (model(sel, a, b) == 32'd0);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      chk("out", out, exp_out);
      chk("zero", {31'd0, zero}, {31'd0, exp_zero});
      case (chk_mode)
        1: begin
          chk({chk_name, " out"}, out, chk_exp);
          chk({chk_name, " zero"}, {31'd0, zero}, {31'd0, (chk_exp == 32'd0)});
          chk({chk_name, " valid"}, {31'd0, out_valid}, 32'd1);
          chk({chk_name, " model"}, model(chk_sel, chk_a, chk_b), chk_exp);
        end
        2: begin
          chk({chk_name, " out"}, out, 32'd0);
          chk({chk_name, " zero"}, {31'd0, zero}, 32'd1);
          chk({chk_name, " valid"}, {31'd0, out_valid}, 32'd0);
        end
        3: begin
          chk({chk_name, " out"}, out, chk_exp);
          chk({chk_name, " valid"}, {31'd0, out_valid}, 32'd0);
        end
        default: ;
      endcase
    end
  end

  // Present one valid operation for exactly one edge.
  task automatic vec(input string nm, input logic [3:0] s, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] e);
    sel      = s;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    lit_mode = 1;
    lit_exp  = e;
    lit_name = nm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 4'd0;
    a        = '0;
    b        = '0;
    lit_mode = 2;
    lit_name = "reset";
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n    = 1'b1;

    // Continuous stream: every vector follows the previous one with no gap.
    vec("and",        4'd0,  32'd12,         32'd10,         32'd8);
    vec("or",         4'd1,  32'd12,         32'd10,         32'd14);
    vec("xor",        4'd4,  32'd10,         32'd3,          32'd9);
    vec("nor",        4'd10, 32'd12,         32'd10,         32'hFFFF_FFF1);
    vec("add",        4'd2,  32'd7,          32'd5,          32'd12);
    vec("sub",        4'd3,  32'd15,         32'd9,          32'd6);
    vec("sub_eq",     4'd3,  32'd5,          32'd5,          32'd0);
    vec("add_wrap",   4'd2,  32'hFFFF_FFFF,  32'd1,          32'd0);
    vec("slt_neg",    4'd5,  32'hFFFF_FFFC,  32'd2,          32'd1);
    vec("sltu_neg",   4'd6,  32'hFFFF_FFFC,  32'd2,          32'd0);
    vec("slt_pos",    4'd5,  32'd2,          32'hFFFF_FFFC,  32'd0);
    vec("sll",        4'd7,  32'd1,          32'd4,          32'd16);
    vec("srl",        4'd8,  32'd32,         32'd3,          32'd4);
    vec("sra",        4'd9,  32'hFFFF_FFF8,  32'd2,          32'hFFFF_FFFE);
    vec("srl_31",     4'd8,  32'h8000_0000,  32'd31,         32'd1);
    vec("sll_33",     4'd7,  32'd1,          32'd33,         32'd2);
    vec("sra_31",     4'd9,  32'h8000_0000,  32'd31,         32'hFFFF_FFFF);
    vec("sltu_big",   4'd6,  32'd2,          32'hFFFF_FFFC,  32'd1);
    vec("rsv_15",     4'd15, 32'd5,          32'd5,          32'd0);
    vec("rsv_11",     4'd11, 32'hDEAD_BEEF,  32'h1234_5678,  32'd0);
    vec("add_last",   4'd2,  32'd100,        32'd23,         32'd123);

    // Idle with changing operands: result must hold.
    in_valid = 1'b0;
    sel      = 4'd1;
    a        = 32'hFFFF_0000;
    b        = 32'h0000_FFFF;
    lit_mode = 3;
    lit_exp  = 32'd123;
    lit_name = "hold";
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-stream, with a valid input on the reset edge.
    vec("pre_rst",    4'd2,  32'd7,          32'd5,          32'd12);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    sel      = 4'd2;
    a        = 32'd1;
    b        = 32'd1;
    lit_mode = 2;
    lit_name = "mid_reset";
    @(posedge clk); #1;
    rst_n    = 1'b1;
    vec("post_rst",   4'd3,  32'd15,         32'd9,          32'd6);
    vec("post_rst2",  4'd0,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000);

    in_valid = 1'b0;
    lit_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
